// File: rtl/wb_pkg.sv
// Shared types for the LEGv8 writeback stage: source/size encodings and the
// control half of the MEM/WB pipeline register.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_LINK = 2'b10,
      WB_RSVD = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LD_B = 2'b00,
      LD_H = 2'b01,
      LD_W = 2'b10,
      LD_D = 2'b11
   } ld_size_e;

   // Width-independent fields; data words and indices live beside it in the stage.
   typedef struct packed {
      logic     valid;
      logic     regWrite;
      wb_sel_e  wbSel;
      ld_size_e ldSize;
      logic     ldSigned;
   } memwb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-side inputs and WB-side outputs of the writeback stage bundled as one bus.
interface wb_stage_if #(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
) ();
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic              mem_valid;
   logic              mem_reg_write;
   logic [REG_AW-1:0] mem_rd;
   logic [1:0]        mem_wb_sel;
   logic [1:0]        mem_ld_size;
   logic              mem_ld_signed;
   logic [OFF_W-1:0]  mem_byte_off;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_read_data;
   logic [DATA_W-1:0] mem_link_data;

   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;

   modport master (
      output mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_ld_size,
             mem_ld_signed, mem_byte_off, mem_alu_result, mem_read_data, mem_link_data,
      input  wb_reg_write, wb_rd, wb_data, wb_valid
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_ld_size,
             mem_ld_signed, mem_byte_off, mem_alu_result, mem_read_data, mem_link_data,
      output wb_reg_write, wb_rd, wb_data, wb_valid
   );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load alignment: align offset down to the access size, shift,
// slice the field and sign- or zero-extend it to DATA_W.
module load_extend
   import wb_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0]          rdata,
   input  ld_size_e                   size,
   input  logic                       isSigned,
   input  logic [$clog2(DATA_W/8)-1:0] off,
   output logic [DATA_W-1:0]          data
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   ld_size_e          effSize;
   logic [OFF_W-1:0]  alignedOff;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              msb;

   // A 32-bit datapath has no double access; treat it as a word.
   assign effSize = (DATA_W == 32 && size == LD_D) ? LD_W : size;

   always_comb begin
      alignedOff = off;
      case (effSize)
         LD_B:    alignedOff = off;
         LD_H:    alignedOff = off & ~OFF_W'(1);
         LD_W:    alignedOff = off & ~OFF_W'(3);
         default: alignedOff = off & ~OFF_W'(7);
      endcase
   end

   assign shifted = rdata >> {alignedOff, 3'b000};

   always_comb begin
      mask = '1;
      msb  = shifted[DATA_W-1];
      case (effSize)
         LD_B: begin
            mask = DATA_W'(8'hFF);
            msb  = shifted[7];
         end
         LD_H: begin
            mask = DATA_W'(16'hFFFF);
            msb  = shifted[15];
         end
         LD_W: begin
            mask = DATA_W'(32'hFFFF_FFFF);
            msb  = shifted[31];
         end
         default: begin
            mask = '1;
            msb  = shifted[DATA_W-1];
         end
      endcase
   end

   assign data = (shifted & mask) | ((isSigned && msb) ? ~mask : '0);

endmodule

// File: rtl/wb_stage.sv
// LEGv8 writeback stage: MEM/WB register, load extraction and source select.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
   import wb_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
`ifdef WB_RETIRE_CNT_EN
   output logic [31:0] retire_count,
`endif
   wb_stage_if.slave   bus
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   memwb_t            ctrl;
   logic [REG_AW-1:0] rdQ;
   logic [OFF_W-1:0]  offQ;
   logic [DATA_W-1:0] aluQ;
   logic [DATA_W-1:0] readQ;
   logic [DATA_W-1:0] linkQ;
   logic [DATA_W-1:0] loadData;
   logic [DATA_W-1:0] selData;

   // Flush only clears valid; the remaining fields are don't-care until the next capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl  <= '0;
         rdQ   <= '0;
         offQ  <= '0;
         aluQ  <= '0;
         readQ <= '0;
         linkQ <= '0;
      end else if (flush) begin
         ctrl.valid <= 1'b0;
      end else if (!stall) begin
         ctrl.valid    <= bus.mem_valid;
         ctrl.regWrite <= bus.mem_reg_write;
         ctrl.wbSel    <= wb_sel_e'(bus.mem_wb_sel);
         ctrl.ldSize   <= ld_size_e'(bus.mem_ld_size);
         ctrl.ldSigned <= bus.mem_ld_signed;
         rdQ           <= bus.mem_rd;
         offQ          <= bus.mem_byte_off;
         aluQ          <= bus.mem_alu_result;
         readQ         <= bus.mem_read_data;
         linkQ         <= bus.mem_link_data;
      end
   end

   load_extend #(
      .DATA_W(DATA_W)
   ) u_load_extend (
      .rdata    (readQ),
      .size     (ctrl.ldSize),
      .isSigned (ctrl.ldSigned),
      .off      (offQ),
      .data     (loadData)
   );

   always_comb begin
      selData = '0;
      case (ctrl.wbSel)
         WB_ALU:  selData = aluQ;
         WB_MEM:  selData = loadData;
         WB_LINK: selData = linkQ;
         default: selData = '0;
      endcase
   end

   assign bus.wb_valid     = ctrl.valid;
   assign bus.wb_rd        = rdQ;
   assign bus.wb_data      = selData;
   assign bus.wb_reg_write = ctrl.valid && ctrl.regWrite
                             && (rdQ != REG_AW'(ZERO_REG)) && (ctrl.wbSel != WB_RSVD);

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retireCnt;

   // A held instruction is counted only on the edge where it leaves WB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retireCnt <= '0;
      end else if (ctrl.valid && !stall) begin
         retireCnt <= retireCnt + 32'd1;
      end
   end

   assign retire_count = retireCnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage against an arithmetic reference model.
module tb_wb_stage;

   logic clk;
   logic reset;
   logic stall;
   logic flush;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   wb_stage_if #(.DATA_W(64), .REG_AW(5)) bus ();

   wb_stage #(
      .DATA_W   (64),
      .REG_AW   (5),
      .ZERO_REG (31)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
`ifdef WB_RETIRE_CNT_EN
      .retire_count (retire_count),
`endif
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the MEM/WB register should hold.
   bit          mValid;
   bit          mKnown;
   bit          mWe;
   logic [4:0]  mRd;
   int          mSel;
   int          mSize;
   bit          mSigned;
   int          mOff;
   logic [63:0] mAlu;
   logic [63:0] mRead;
   logic [63:0] mLink;
   int unsigned mCnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] refLoad(input logic [63:0] raw, input int size,
                                           input bit sgn, input int off);
      int          nb;
      int          al;
      logic [63:0] sh;
      logic [63:0] lim;
      logic [63:0] f;
      nb = 1 << size;
      al = off - (off % nb);
      sh = raw >> (8 * al);
      if (nb == 8) return sh;
      lim = 64'd1 << (8 * nb);
      f   = sh % lim;
      if (sgn && f >= (lim / 2)) f = f - lim;
      return f;
   endfunction

   function automatic logic [63:0] refData();
      case (mSel)
         0:       return mAlu;
         1:       return refLoad(mRead, mSize, mSigned, mOff);
         2:       return mLink;
         default: return 64'd0;
      endcase
   endfunction

   task automatic modelReset();
      mValid = 0; mKnown = 1; mWe = 0; mRd = '0; mSel = 0; mSize = 0;
      mSigned = 0; mOff = 0; mAlu = '0; mRead = '0; mLink = '0; mCnt = 0;
   endtask

   task automatic drive(input bit v, input bit we, input int rd, input int sel,
                        input int size, input bit sgn, input int off,
                        input logic [63:0] alu, input logic [63:0] rdata,
                        input logic [63:0] link);
      bus.mem_valid      = v;
      bus.mem_reg_write  = we;
      bus.mem_rd         = 5'(rd);
      bus.mem_wb_sel     = 2'(sel);
      bus.mem_ld_size    = 2'(size);
      bus.mem_ld_signed  = sgn;
      bus.mem_byte_off   = 3'(off);
      bus.mem_alu_result = alu;
      bus.mem_read_data  = rdata;
      bus.mem_link_data  = link;
   endtask

   task automatic checkAll(input string tag);
      bit expWe;
      expWe = mValid && mWe && (mRd != 5'd31) && (mSel != 3);
      chk({tag, ".valid"}, 64'(bus.wb_valid), 64'(mValid));
      chk({tag, ".we"}, 64'(bus.wb_reg_write), 64'(expWe));
      if (mKnown) begin
         chk({tag, ".rd"}, 64'(bus.wb_rd), 64'(mRd));
         chk({tag, ".data"}, bus.wb_data, refData());
      end
`ifdef WB_RETIRE_CNT_EN
      chk({tag, ".cnt"}, 64'(retire_count), 64'(mCnt));
`endif
   endtask

   // One clock: snapshot inputs, advance the model at the edge, check after it.
   task automatic step(input string tag);
      bit          sStall, sFlush, sV, sW, sSg;
      logic [4:0]  sRd;
      int          sSel, sSize, sOff;
      logic [63:0] sAlu, sRead, sLink;
      sStall = stall; sFlush = flush;
      sV = bus.mem_valid; sW = bus.mem_reg_write; sRd = bus.mem_rd;
      sSel = int'(bus.mem_wb_sel); sSize = int'(bus.mem_ld_size);
      sSg = bus.mem_ld_signed; sOff = int'(bus.mem_byte_off);
      sAlu = bus.mem_alu_result; sRead = bus.mem_read_data; sLink = bus.mem_link_data;
      if (mValid && !sStall) mCnt++;
      @(posedge clk);
      if (sFlush) begin
         mValid = 0;
         mKnown = 0;
      end else if (!sStall) begin
         mValid = sV; mWe = sW; mRd = sRd; mSel = sSel; mSize = sSize;
         mSigned = sSg; mOff = sOff; mAlu = sAlu; mRead = sRead; mLink = sLink;
         mKnown = 1;
      end
      #1;
      checkAll(tag);
      @(negedge clk);
   endtask

   task automatic checkZero(input string tag);
      chk({tag, ".valid"}, 64'(bus.wb_valid), 64'd0);
      chk({tag, ".we"}, 64'(bus.wb_reg_write), 64'd0);
      chk({tag, ".rd"}, 64'(bus.wb_rd), 64'd0);
      chk({tag, ".data"}, bus.wb_data, 64'd0);
`ifdef WB_RETIRE_CNT_EN
      chk({tag, ".cnt"}, 64'(retire_count), 64'd0);
`endif
   endtask

   task automatic midCycleReset(input string tag);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 checkZero(tag);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   localparam logic [63:0] LD_WORD = 64'h0000_0000_8000_FF80;

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      modelReset();
      #12 checkZero("rst_init");
      @(negedge clk);
      reset = 1'b0;

      // Basic ALU write
      drive(1, 1, 3, 0, 0, 0, 0, 64'd155, '0, '0);
      step("alu");
      chk("alu.we_lit", 64'(bus.wb_reg_write), 64'd1);
      chk("alu.rd_lit", 64'(bus.wb_rd), 64'd3);
      chk("alu.data_lit", bus.wb_data, 64'd155);

      // Reset asserted mid-cycle while stalling a valid instruction
      stall = 1'b1;
      midCycleReset("rst_mid");
      stall = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      step("rst_release");

      // Load extraction
      drive(1, 1, 7, 1, 0, 1, 0, '0, LD_WORD, '0);
      step("ldb");
      chk("ldb.lit", bus.wb_data, 64'hFFFF_FFFF_FFFF_FF80);
      drive(1, 1, 7, 1, 1, 0, 2, '0, LD_WORD, '0);
      step("ldh");
      chk("ldh.lit", bus.wb_data, 64'h0000_0000_0000_8000);
      drive(1, 1, 7, 1, 2, 1, 3, '0, LD_WORD, '0);
      step("ldw");
      chk("ldw.lit", bus.wb_data, 64'hFFFF_FFFF_8000_FF80);

      // Link and XZR
      drive(1, 1, 30, 2, 0, 0, 0, '0, '0, 64'd99);
      step("link");
      chk("link.data_lit", bus.wb_data, 64'd99);
      chk("link.we_lit", 64'(bus.wb_reg_write), 64'd1);
      drive(1, 1, 31, 2, 0, 0, 0, '0, '0, 64'd99);
      step("xzr");
      chk("xzr.we_lit", 64'(bus.wb_reg_write), 64'd0);

      // Stall holds for three cycles while inputs change
      drive(1, 1, 5, 0, 0, 0, 0, 64'd12, '0, '0);
      step("stall_cap");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 9, 0, 0, 0, 0, 64'(777 + i), '0, '0);
         step("stall_hold");
         chk("stall.rd_lit", 64'(bus.wb_rd), 64'd5);
         chk("stall.data_lit", bus.wb_data, 64'd12);
         chk("stall.we_lit", 64'(bus.wb_reg_write), 64'd1);
      end
      flush = 1'b1;
      step("flush_stall");
      chk("flush.valid_lit", 64'(bus.wb_valid), 64'd0);
      chk("flush.we_lit", 64'(bus.wb_reg_write), 64'd0);
      flush = 1'b0;
      stall = 1'b0;

      // Reserved select
      drive(1, 1, 4, 3, 0, 0, 0, 64'hDEAD, 64'hBEEF, 64'hCAFE);
      step("rsvd");
      chk("rsvd.data_lit", bus.wb_data, 64'd0);
      chk("rsvd.we_lit", 64'(bus.wb_reg_write), 64'd0);

`ifdef WB_RETIRE_CNT_EN
      midCycleReset("cnt_rst");
      drive(1, 1, 1, 0, 0, 0, 0, 64'd1, '0, '0); step("cnt_i1");
      drive(1, 1, 2, 0, 0, 0, 0, 64'd2, '0, '0); step("cnt_i2");
      drive(1, 1, 3, 0, 0, 0, 0, 64'd3, '0, '0);
      stall = 1'b1; step("cnt_s1"); step("cnt_s2");
      stall = 1'b0; step("cnt_i3");
      drive(1, 1, 4, 0, 0, 0, 0, 64'd4, '0, '0); step("cnt_i4");
      drive(0, 0, 0, 0, 0, 0, 0, '0, '0, '0); step("cnt_b1"); step("cnt_b2");
      chk("cnt.four_lit", 64'(retire_count), 64'd4);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 31)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
               $urandom_range(0, 7),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         step("rnd");
      end
      stall = 1'b0;
      flush = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage for the pipelined LEGv8 core. It owns the MEM/WB pipeline register and selects between ALU result, load data and link data.
- Load data is aligned and extended for byte, half, word and double loads.
- Drives the register-file write port and a forwarding bus.
- Supports stall (hold) and flush (bubble) from hazard control.

Parameters:
- DATA_W, 64, datapath width; legal values 32 or 64.
- REG_AW, 5, register index width.
- ZERO_REG, 31, index of XZR; writes to it are suppressed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold the MEM/WB register contents
- flush  in  1  load a bubble into the MEM/WB register
- mem_valid  in  1  instruction present in MEM
- mem_reg_write  in  1  instruction writes a register
- mem_rd  in  REG_AW  destination register
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 MEM, 10 LINK, 11 reserved
- mem_ld_size  in  2  load size: 00 byte, 01 half, 10 word, 11 double
- mem_ld_signed  in  1  1 = sign-extend, 0 = zero-extend
- mem_byte_off  in  $clog2(DATA_W/8)  byte offset of the load within the read word
- mem_alu_result  in  DATA_W  ALU result
- mem_read_data  in  DATA_W  raw data-memory read word
- mem_link_data  in  DATA_W  PC+4 for BL
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  REG_AW  register-file write index
- wb_data  out  DATA_W  register-file write data; also the forwarding data
- wb_valid  out  1  valid instruction in WB

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-high. It clears every register immediately, independent of clk.
  - Outputs during reset: wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0.
- Pipeline register update, on each rising clk edge:
  - flush=1: valid bit cleared, other fields don't-care. flush has priority over stall.
  - else stall=1: all fields hold.
  - else: all mem_* inputs captured.
- Latency: inputs are visible on the wb_* outputs one cycle after capture. All wb_* outputs are combinational from the register.
- Load extraction, for wb_sel=01:
  - shifted = read_data >> (8 × aligned_off).
  - aligned_off = byte_off with its low log2(size_bytes) bits cleared. Misaligned offsets are therefore aligned down.
  - Take the low 8/16/32/64 bits of shifted.
  - ld_signed=1: extend with the field's MSB. ld_signed=0: zero-fill.
  - When DATA_W=32, size 11 is treated as word.
- Source select:
  - 00 → alu_result.
  - 01 → extracted load.
  - 10 → link_data.
  - 11 → wb_data=0 and wb_reg_write=0.
- Write enable: wb_reg_write = valid & reg_write & (rd != ZERO_REG) & (wb_sel != 11).
- wb_data is still driven when the enable is suppressed; the register file must ignore it.
- Stall with a valid instruction held: wb_reg_write stays asserted for every held cycle. Rewriting the same value is harmless by design.
- Reset mid-stall or mid-flush: reset wins; the register is empty on release.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count, 32 bits.
  - Increments by 1 on each clk edge where wb_valid=1 and stall=0, so a held instruction is counted once.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- When undefined: no port and no counter logic.

Decomposition:
- Package wb_pkg holds:
  - typedef wb_sel_e: WB_ALU, WB_MEM, WB_LINK, WB_RSVD.
  - typedef ld_size_e: LD_B, LD_H, LD_W, LD_D.
  - struct memwb_t, the pipeline-register fields.
- One sub-module, load_extend: combinational align, slice and extend, parametrised by DATA_W.

Test Plan:
- Reset and basic path:
  - Assert reset mid-cycle → all outputs 0 immediately.
  - Release, then valid ALU write rd=3, alu=155 → next cycle wb_reg_write=1, wb_rd=3, wb_data=155.
- Load extraction: read_data=0x00000000_8000FF80, sel=MEM.
  - Byte, off=0, signed → 0xFFFFFFFF_FFFFFF80.
  - Half, off=2, unsigned → 0x0000_0000_0000_8000.
  - Word, off=3 (aligns to 0), signed → 0xFFFFFFFF_8000FF80.
- Link and zero-register cases:
  - sel=LINK, link=99, rd=30 → wb_data=99, write enabled.
  - Same with rd=31 → wb_reg_write=0.
- Stall and flush:
  - Stall 3 cycles holding rd=5/data=12 → outputs constant for all 3 cycles.
  - flush with stall=1 → wb_valid=0 next cycle.
- Reserved select: sel=11, reg_write=1 → wb_data=0, wb_reg_write=0.
- Retire counter (WB_RETIRE_CNT_EN):
  - 4 valid instructions with one 2-cycle stall → retire_count=4.
  - Preload to wrap: 0xFFFFFFFF → 0 after one retire.
